conv3x3_filter: RTL and testbench

//  Parametrised 3x3 edge/convolution filter for the laplace user-logic pipeline.

---
 rtl/conv3x3_filter.sv | 186 ++++++++++++++++++
 tb/tb_conv3x3_filter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_filter.sv
// conv3x3_filter: 3x3 column-streamed convolution filter (Laplace, Sobel-x,
// Sobel-y, identity) with magnitude/shift/saturate output and a credit-managed
// first-word-fall-through output FIFO.
module conv3x3_filter #(
   parameter int PIX_W     = 8,
   parameter int SHIFT     = 3,
   parameter int OUT_DEPTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [PIX_W-1:0] i_pixel_1,
   input  logic [PIX_W-1:0] i_pixel_2,
   input  logic [PIX_W-1:0] i_pixel_3,
   input  logic             i_sof,
   input  logic [1:0]       i_mode,
   input  logic             i_pixel_valid,
   output logic             o_pixel_ack,
   output logic             o_pixel_valid,
   input  logic             i_pixel_ack,
   output logic [PIX_W-1:0] o_pixel
);

   localparam int KW = PIX_W + 5;
   localparam int AW = $clog2(OUT_DEPTH);
   localparam logic [PIX_W-1:0] PIX_MAX = '1;

   localparam logic [1:0] MODE_LAPLACE = 2'd0;
   localparam logic [1:0] MODE_SOBEL_X = 2'd1;
   localparam logic [1:0] MODE_SOBEL_Y = 2'd2;
   localparam logic [1:0] MODE_IDENT   = 2'd3;

   // Zero-extend an unsigned pixel into the signed kernel width.
   function automatic logic signed [KW-1:0] ext(input logic [PIX_W-1:0] p);
      return signed'({5'b0, p});
   endfunction

   // Magnitude, right shift (skipped for identity) and clamp to the pixel range.
   function automatic logic [PIX_W-1:0] abs_shift_sat(input logic signed [KW-1:0] k,
                                                      input logic ident);
      logic [KW-1:0] mag;
      mag = k[KW-1] ? $unsigned(-k) : $unsigned(k);
      if (!ident) mag = mag >> SHIFT;
      if (mag > KW'(PIX_MAX)) return PIX_MAX;
      return mag[PIX_W-1:0];
   endfunction

   logic                    accept;
   logic                    result_en;
   logic [1:0]              col_cnt;
   logic [1:0]              mode_q;
   logic [PIX_W-1:0]        win_p0 [3][3];
   logic                    vld_p0;

   logic signed [KW-1:0]    pos_sum;
   logic signed [KW-1:0]    neg_sum;
   logic signed [KW-1:0]    pos_p1;
   logic signed [KW-1:0]    neg_p1;
   logic [1:0]              mode_p1;
   logic                    vld_p1;

   logic [PIX_W-1:0]        res_p2;
   logic                    vld_p2;

   logic [PIX_W-1:0]        mem [OUT_DEPTH];
   logic [AW-1:0]           wr_ptr;
   logic [AW-1:0]           rd_ptr;
   logic [AW:0]             fifo_count;
   logic [PIX_W-1:0]        last_pix;
   logic                    fifo_rd;
   logic [AW+1:0]           occupancy;

   assign accept    = i_pixel_valid & o_pixel_ack;
   // A result exists once three columns of the current line are in the window.
   assign result_en = accept & ~i_sof & (col_cnt >= 2'd2);

   // Every result not yet in the FIFO holds a credit, so the FIFO never overflows.
   assign occupancy   = (AW+2)'(fifo_count) + (AW+2)'(vld_p0) + (AW+2)'(vld_p1)
                        + (AW+2)'(vld_p2);
   assign o_pixel_ack = i_rst_n & (occupancy < (AW+2)'(OUT_DEPTH));

   assign o_pixel_valid = (fifo_count != '0);
   assign o_pixel       = o_pixel_valid ? mem[rd_ptr] : last_pix;
   assign fifo_rd       = o_pixel_valid & i_pixel_ack;

   // Window shift, column counter, kernel latch and first-stage valid.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         col_cnt <= '0;
         mode_q  <= MODE_LAPLACE;
         vld_p0  <= 1'b0;
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               win_p0[r][c] <= '0;
      end else begin
         vld_p0 <= result_en;
         if (accept) begin
            for (int r = 0; r < 3; r++) begin
               win_p0[r][2] <= win_p0[r][1];
               win_p0[r][1] <= win_p0[r][0];
            end
            win_p0[0][0] <= i_pixel_1;
            win_p0[1][0] <= i_pixel_2;
            win_p0[2][0] <= i_pixel_3;
            if (i_sof) begin
               col_cnt <= 2'd1;
               mode_q  <= i_mode;
            end else if (col_cnt != 2'd3) begin
               col_cnt <= col_cnt + 2'd1;
            end
         end
      end
   end

   // Positive and negative kernel halves for the selected mode.
   always_comb begin
      pos_sum = '0;
      neg_sum = '0;
      case (mode_q)
         MODE_LAPLACE: begin
            pos_sum = ext(win_p0[1][1]) <<< 3;
            neg_sum = ext(win_p0[0][0]) + ext(win_p0[0][1]) + ext(win_p0[0][2])
                    + ext(win_p0[1][0]) + ext(win_p0[1][2])
                    + ext(win_p0[2][0]) + ext(win_p0[2][1]) + ext(win_p0[2][2]);
         end
         MODE_SOBEL_X: begin
            pos_sum = ext(win_p0[0][0]) + (ext(win_p0[1][0]) <<< 1) + ext(win_p0[2][0]);
            neg_sum = ext(win_p0[0][2]) + (ext(win_p0[1][2]) <<< 1) + ext(win_p0[2][2]);
         end
         MODE_SOBEL_Y: begin
            pos_sum = ext(win_p0[0][0]) + (ext(win_p0[0][1]) <<< 1) + ext(win_p0[0][2]);
            neg_sum = ext(win_p0[2][0]) + (ext(win_p0[2][1]) <<< 1) + ext(win_p0[2][2]);
         end
         default: begin
            pos_sum = ext(win_p0[1][1]);
            neg_sum = '0;
         end
      endcase
   end

   // Pipeline control: valids and kernel mode travel with the data.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         vld_p1  <= 1'b0;
         vld_p2  <= 1'b0;
         mode_p1 <= MODE_LAPLACE;
      end else begin
         vld_p1  <= vld_p0;
         vld_p2  <= vld_p1;
         mode_p1 <= mode_q;
      end
   end

   // Pipeline data: partial sums, then magnitude/shift/saturate.
   always_ff @(posedge i_clk) begin
      pos_p1 <= pos_sum;
      neg_p1 <= neg_sum;
      res_p2 <= abs_shift_sat(pos_p1 - neg_p1, mode_p1 == MODE_IDENT);
   end

   // FIFO storage write.
   always_ff @(posedge i_clk) begin
      if (vld_p2) mem[wr_ptr] <= res_p2;
   end

   // FIFO pointers, count and the held output value.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         last_pix   <= '0;
      end else begin
         if (vld_p2) wr_ptr <= wr_ptr + AW'(1);
         if (fifo_rd) begin
            rd_ptr   <= rd_ptr + AW'(1);
            last_pix <= mem[rd_ptr];
         end
         case ({vld_p2, fifo_rd})
            2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
            2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

endmodule

// File: tb/tb_conv3x3_filter.sv
// tb_conv3x3_filter: directed and randomized column streams into two filter
// builds (SHIFT=3 and SHIFT=0) sharing all inputs, checked against a
// coefficient-matrix reference model with a per-build expected-output queue.
module tb_conv3x3_filter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] p1 = '0, p2 = '0, p3 = '0;
   logic       sof = 1'b0;
   logic [1:0] mode = '0;
   logic       valid = 1'b0;
   logic       dack = 1'b1;
   logic       ack_a, vout_a, ack_b, vout_b;
   logic [7:0] pix_a, pix_b;

   always #5 clk = ~clk;

   conv3x3_filter #(.PIX_W(8), .SHIFT(3), .OUT_DEPTH(4)) dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_pixel_1(p1), .i_pixel_2(p2), .i_pixel_3(p3),
      .i_sof(sof), .i_mode(mode), .i_pixel_valid(valid), .o_pixel_ack(ack_a),
      .o_pixel_valid(vout_a), .i_pixel_ack(dack), .o_pixel(pix_a));

   conv3x3_filter #(.PIX_W(8), .SHIFT(0), .OUT_DEPTH(4)) dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_pixel_1(p1), .i_pixel_2(p2), .i_pixel_3(p3),
      .i_sof(sof), .i_mode(mode), .i_pixel_valid(valid), .o_pixel_ack(ack_b),
      .o_pixel_valid(vout_b), .i_pixel_ack(dack), .o_pixel(pix_b));

   int nchk = 0;
   int nerr = 0;
   int n_acc = 0;
   int n_out = 0;
   bit rand_ack = 0;

   // Kernel coefficients indexed [mode][row][col], col 0 = newest column.
   int kc [4][3][3] = '{
      '{'{-1, -1, -1}, '{-1,  8, -1}, '{-1, -1, -1}},
      '{'{ 1,  0, -1}, '{ 2,  0, -2}, '{ 1,  0, -1}},
      '{'{ 1,  2,  1}, '{ 0,  0,  0}, '{-1, -2, -1}},
      '{'{ 0,  0,  0}, '{ 0,  1,  0}, '{ 0,  0,  0}}};

   int ct[$], cm[$], cb[$];
   int mdl_mode = 0;
   int exp_a[$], exp_b[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
      nchk++;
      assert (got === expv) else begin
         nerr++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, expv);
      end
   endtask

   function automatic int filt(input int k, input int m, input int sh);
      int a;
      if (m == 3) return k;
      a = (k < 0) ? -k : k;
      a = a >>> sh;
      return (a > 255) ? 255 : a;
   endfunction

   task automatic model_reset();
      ct.delete(); cm.delete(); cb.delete();
      exp_a.delete(); exp_b.delete();
      mdl_mode = 0;
   endtask

   // Lines start at sof; a pixel is produced for every column once the line has three.
   task automatic model_accept(input int t, input int m, input int b, input bit s, input int md);
      int k;
      if (s) begin
         ct.delete(); cm.delete(); cb.delete();
         mdl_mode = md;
      end
      ct.push_back(t); cm.push_back(m); cb.push_back(b);
      if (ct.size() > 3) begin
         void'(ct.pop_front()); void'(cm.pop_front()); void'(cb.pop_front());
      end
      if (ct.size() == 3) begin
         k = 0;
         for (int c = 0; c < 3; c++) begin
            k += kc[mdl_mode][0][c] * ct[2-c] + kc[mdl_mode][1][c] * cm[2-c]
               + kc[mdl_mode][2][c] * cb[2-c];
         end
         exp_a.push_back(filt(k, mdl_mode, 3));
         exp_b.push_back(filt(k, mdl_mode, 0));
      end
   endtask

   // Monitor: score output transfers and feed accepted columns to the model.
   always @(negedge clk) begin
      if (rst_n) begin
         if (vout_a && dack) begin
            if (exp_a.size() == 0) begin
               check("spurious_valid", 32'(vout_a), 32'd0);
            end else begin
               check("out_shift3", 32'(pix_a), 32'(exp_a.pop_front()));
               check("out_shift0", 32'(pix_b), 32'(exp_b.pop_front()));
               n_out++;
            end
         end
         if (valid && ack_a) begin
            model_accept(int'(p1), int'(p2), int'(p3), sof, int'(mode));
            n_acc++;
         end
      end
   end

   task automatic send_col(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                           input logic s, input logic [1:0] md);
      int  t;
      logic got;
      t = 0;
      got = 1'b0;
      p1 = a; p2 = b; p3 = c; sof = s; mode = md; valid = 1'b1;
      while (!got && t < 200) begin
         @(negedge clk);
         got = ack_a;
         @(posedge clk);
         #1;
         t++;
         if (rand_ack) dack = ($urandom_range(0, 3) != 0);
      end
      if (!got) check("accept_timeout", 32'(ack_a), 32'd1);
   endtask

   task automatic idle(input int n);
      valid = 1'b0;
      repeat (n) begin
         sof = 1'($urandom_range(0, 1));
         mode = 2'($urandom_range(0, 3));
         p1 = 8'($urandom);
         @(posedge clk);
         #1;
      end
      sof = 1'b0;
   endtask

   task automatic drain();
      int t;
      valid = 1'b0;
      rand_ack = 0;
      dack = 1'b1;
      t = 0;
      while ((exp_a.size() != 0 || vout_a) && t < 300) begin
         @(posedge clk);
         #1;
         t++;
      end
      repeat (2) @(posedge clk);
      #1;
      check("drain_left", 32'(exp_a.size()), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   acc0, out0, tcyc;
      logic acc;
      logic [7:0] cmid;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 32'(vout_a), 32'd0);
      check("rst_ack", 32'(ack_a), 32'd0);
      check("rst_pix", 32'(pix_a), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("ack_after_rst", 32'(ack_a), 32'd1);
      @(posedge clk);
      #1;

      // Flat Laplace: one zero result, three edges after the third accept
      send_col(8'd100, 8'd100, 8'd100, 1'b1, 2'd0);
      send_col(8'd100, 8'd100, 8'd100, 1'b0, 2'd0);
      send_col(8'd100, 8'd100, 8'd100, 1'b0, 2'd0);
      valid = 1'b0;
      @(negedge clk);
      check("lat_T0", 32'(vout_a), 32'd0);
      @(negedge clk);
      @(negedge clk);
      check("lat_T2", 32'(vout_a), 32'd0);
      @(negedge clk);
      check("lat_T3_valid", 32'(vout_a), 32'd1);
      check("lat_T3_pix", 32'(pix_a), 32'd0);
      drain();

      // Laplace extremes
      send_col(8'd0, 8'd0, 8'd0, 1'b1, 2'd0);
      send_col(8'd0, 8'd255, 8'd0, 1'b0, 2'd0);
      send_col(8'd0, 8'd0, 8'd0, 1'b0, 2'd0);
      send_col(8'd255, 8'd255, 8'd255, 1'b1, 2'd0);
      send_col(8'd255, 8'd0, 8'd255, 1'b0, 2'd0);
      send_col(8'd255, 8'd255, 8'd255, 1'b0, 2'd0);
      drain();
      check("lap_hold_a", 32'(pix_a), 32'd255);
      check("lap_hold_b", 32'(pix_b), 32'd255);
      check("empty_valid", 32'(vout_a), 32'd0);

      // Sobel-x both polarities
      send_col(8'd0, 8'd0, 8'd0, 1'b1, 2'd1);
      send_col(8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 2'd1);
      send_col(8'd200, 8'd200, 8'd200, 1'b0, 2'd1);
      send_col(8'd200, 8'd200, 8'd200, 1'b1, 2'd1);
      send_col(8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 2'd1);
      send_col(8'd0, 8'd0, 8'd0, 1'b0, 2'd1);
      drain();
      check("sobx_hold_a", 32'(pix_a), 32'd100);
      check("sobx_hold_b", 32'(pix_b), 32'd255);

      // Sobel-y, saturating only in the unshifted build
      send_col(8'd255, 8'($urandom), 8'd0, 1'b1, 2'd2);
      send_col(8'd255, 8'($urandom), 8'd0, 1'b0, 2'd0);
      send_col(8'd255, 8'($urandom), 8'd0, 1'b0, 2'd3);
      drain();
      check("soby_hold_a", 32'(pix_a), 32'd127);
      check("soby_hold_b", 32'(pix_b), 32'd255);

      // Identity passthrough; mode on non-sof columns must be ignored
      cmid = 8'($urandom);
      send_col(8'($urandom), 8'($urandom), 8'($urandom), 1'b1, 2'd3);
      send_col(8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 2'd0);
      send_col(8'($urandom), cmid, 8'($urandom), 1'b0, 2'd1);
      send_col(8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 2'd2);
      drain();
      check("ident_hold_a", 32'(pix_a), 32'(cmid));
      check("ident_hold_b", 32'(pix_b), 32'(cmid));

      // Randomized frames, modes, gaps and downstream stalls
      rand_ack = 1;
      for (int i = 0; i < 200; i++) begin
         send_col(8'($urandom), 8'($urandom), 8'($urandom),
                  (i == 0) || ($urandom_range(0, 9) == 0), 2'($urandom_range(0, 3)));
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      drain();

      // Long downstream stall: credit throttles input, nothing is lost
      acc0 = n_acc;
      out0 = n_out;
      dack = 1'b0;
      sof = 1'b1;
      mode = 2'($urandom_range(0, 3));
      valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         p1 = 8'($urandom); p2 = 8'($urandom); p3 = 8'($urandom);
         @(negedge clk);
         acc = ack_a;
         @(posedge clk);
         #1;
         if (acc) sof = 1'b0;
      end
      valid = 1'b0;
      check("stall_accepts", 32'(n_acc - acc0), 32'd6);
      check("stall_ack_low", 32'(ack_a), 32'd0);
      check("stall_fifo_valid", 32'(vout_a), 32'd1);
      drain();
      check("stall_out_count", 32'(n_out - out0), 32'(n_acc - acc0 - 2));

      // Reset mid-stream with a full FIFO
      dack = 1'b0;
      sof = 1'b1;
      mode = 2'd1;
      valid = 1'b1;
      tcyc = 0;
      while (tcyc < 15) begin
         p1 = 8'($urandom); p2 = 8'($urandom); p3 = 8'($urandom);
         @(negedge clk);
         acc = ack_a;
         @(posedge clk);
         #1;
         if (acc) sof = 1'b0;
         tcyc++;
      end
      check("pre_rst_full", 32'(vout_a), 32'd1);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("midrst_valid", 32'(vout_a), 32'd0);
      check("midrst_ack", 32'(ack_a), 32'd0);
      check("midrst_pix_a", 32'(pix_a), 32'd0);
      check("midrst_pix_b", 32'(pix_b), 32'd0);
      valid = 1'b0;
      dack = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      acc0 = n_acc;
      out0 = n_out;
      send_col(8'($urandom), 8'($urandom), 8'($urandom), 1'b1, 2'($urandom_range(0, 3)));
      for (int i = 0; i < 4; i++)
         send_col(8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 2'($urandom_range(0, 3)));
      drain();
      check("post_rst_count", 32'(n_out - out0), 32'(n_acc - acc0 - 2));

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
